// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for inst_fetch_unit: instruction-memory request/response,
// the downstream valid/ready instruction stream, and the redirect/halt
// controls from later pipeline stages.
// master = the fetch unit; slave = its environment (memory, decode, branch unit).
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] imemAddrOut;
  logic              imemReqOut;
  logic [INST_W-1:0] imemDataIn;
  logic              instValidOut;
  logic              instReadyIn;
  logic [INST_W-1:0] instOut;
  logic [4:0]        opcodeOut;
  logic [ADDR_W-1:0] pcOut;
  logic              redirectIn;
  logic [ADDR_W-1:0] redirectPcIn;
  logic              haltIn;

  modport master (
    output imemAddrOut, imemReqOut, instValidOut, instOut, opcodeOut, pcOut,
    input  imemDataIn, instReadyIn, redirectIn, redirectPcIn, haltIn
  );

  modport slave (
    input  imemAddrOut, imemReqOut, instValidOut, instOut, opcodeOut, pcOut,
    output imemDataIn, instReadyIn, redirectIn, redirectPcIn, haltIn
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: pipeline front end. Holds the PC, issues word fetches to a
// one-cycle synchronous instruction memory, buffers returned words with their
// PCs in a 2-entry FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and any in-flight fetch (epoch tag) and reloads
// the PC; haltIn only suppresses new fetches.
// Optional build macro FETCH_PERF_EN adds saturating stall/flush counters.
module inst_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perfStallCntOut,
  output logic [15:0]        perfFlushCntOut
`endif
);

  // Control state
  logic [ADDR_W-1:0] pc_reg;
  logic [1:0]        count;
  logic              inflight;
  logic              inflight_epoch;
  logic              epoch;

  // Data state: PC of the outstanding request and the two FIFO slots (head first)
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] tail_pc;
  logic [INST_W-1:0] tail_inst;

  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [INST_W-1:0] head_out;

  // Handshake, response acceptance and issue decision for this cycle
  always_comb begin
    valid     = (count != 2'd0);
    pop       = valid & bus.instReadyIn;
    // a response is kept only if its request belongs to the current epoch
    // and no redirect is flushing the buffer this cycle
    push      = inflight & (inflight_epoch == epoch) & ~bus.redirectIn;
    // count + inflight - pop; pop implies count >= 1, so no underflow
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // rst_n keeps the request low while reset is held asynchronously
    issue     = rst_n & ~bus.haltIn & ~bus.redirectIn & (occupancy < 3'd2);
  end

  // Output drive; head fields read as zero whenever the FIFO is empty
  always_comb begin
    head_out         = valid ? head_inst : '0;
    bus.imemReqOut   = issue;
    bus.imemAddrOut  = pc_reg;
    bus.instValidOut = valid;
    bus.instOut      = head_out;
    bus.opcodeOut    = head_out[INST_W-1 -: 5];
    bus.pcOut        = valid ? head_pc : '0;
  end

  // PC, FIFO occupancy, in-flight tag and epoch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      count          <= 2'd0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight       <= issue;
      inflight_epoch <= epoch;
      if (bus.redirectIn) begin
        pc_reg <= bus.redirectPcIn;
        epoch  <= ~epoch;
        count  <= 2'd0;
      end else begin
        if (issue) pc_reg <= pc_reg + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO payload and in-flight PC; meaning is qualified by count/inflight
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc_reg;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) begin
          head_pc   <= inflight_pc;
          head_inst <= bus.imemDataIn;
        end else begin
          tail_pc   <= inflight_pc;
          tail_inst <= bus.imemDataIn;
        end
      end
      2'b01: begin
        head_pc   <= tail_pc;
        head_inst <= tail_inst;
      end
      2'b11: begin
        if (count == 2'd1) begin
          head_pc   <= inflight_pc;
          head_inst <= bus.imemDataIn;
        end else begin
          head_pc   <= tail_pc;
          head_inst <= tail_inst;
          tail_pc   <= inflight_pc;
          tail_inst <= bus.imemDataIn;
        end
      end
      default: ;
    endcase
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: decode back-pressure cycles and redirect cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfStallCntOut <= 16'd0;
      perfFlushCntOut <= 16'd0;
    end else begin
      if (valid && !bus.instReadyIn && perfStallCntOut != 16'hFFFF)
        perfStallCntOut <= perfStallCntOut + 16'd1;
      if (bus.redirectIn && perfFlushCntOut != 16'hFFFF)
        perfFlushCntOut <= perfFlushCntOut + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a cycle table drives ready/redirect/
// halt and checks request, address, valid and head PC each cycle; a scoreboard
// queue of expected PCs is compared on every handshake together with the
// instruction word and opcode. Hand-written sequences cover mid-run reset and
// (with FETCH_PERF_EN) the performance counters.
module tb_inst_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  inst_fetch_unit_if #(.ADDR_W(8), .INST_W(32)) bus();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  inst_fetch_unit #(.ADDR_W(8), .INST_W(32), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perfStallCntOut (perf_stall),
    .perfFlushCntOut (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: opcode varies with the address
  function automatic logic [31:0] inst_of(input logic [7:0] a);
    return {~a[4:0], 3'b101, a, 8'hA5, a};
  endfunction

  // One-cycle synchronous memory model
  logic [31:0] imem_q;
  always @(posedge clk) begin
    if (bus.imemReqOut) imem_q <= inst_of(bus.imemAddrOut);
  end
  assign bus.imemDataIn = imem_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       halt;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [7:0] rpc,
                              input logic halt, input logic req, input logic [7:0] addr,
                              input logic vld, input logic [7:0] pc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.halt = halt;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  vec_t       vecs[38];
  logic [7:0] sb[$];

  task automatic start_from_reset();
    rst_n = 1'b0;
    bus.instReadyIn  = 1'b0;
    bus.redirectIn   = 1'b0;
    bus.redirectPcIn = 8'h00;
    bus.haltIn       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_pcs[17];
    logic [7:0] e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.instReadyIn  = 1'b0;
    bus.redirectIn   = 1'b0;
    bus.redirectPcIn = 8'h00;
    bus.haltIn       = 1'b0;

    //          rdy rd  rpc    hlt req addr   vld pc
    vecs[0]  = mk(1, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, 0, 8'h00, 0, 1, 8'h01, 0, 8'h00);
    vecs[2]  = mk(1, 0, 8'h00, 0, 1, 8'h02, 1, 8'h00);
    vecs[3]  = mk(1, 0, 8'h00, 0, 1, 8'h03, 1, 8'h01);
    vecs[4]  = mk(0, 0, 8'h00, 0, 0, 8'h04, 1, 8'h02);
    vecs[5]  = mk(0, 0, 8'h00, 0, 0, 8'h04, 1, 8'h02);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h04, 1, 8'h02);
    vecs[7]  = mk(0, 0, 8'h00, 0, 0, 8'h04, 1, 8'h02);
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'h04, 1, 8'h02);
    vecs[9]  = mk(1, 0, 8'h00, 0, 1, 8'h04, 1, 8'h02);
    vecs[10] = mk(1, 0, 8'h00, 0, 1, 8'h05, 1, 8'h03);
    vecs[11] = mk(1, 0, 8'h00, 0, 1, 8'h06, 1, 8'h04);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 8'h07, 1, 8'h05);
    vecs[13] = mk(1, 0, 8'h00, 0, 1, 8'h07, 1, 8'h05);
    vecs[14] = mk(1, 1, 8'h40, 0, 0, 8'h08, 1, 8'h06);
    vecs[15] = mk(1, 0, 8'h00, 0, 1, 8'h40, 0, 8'h00);
    vecs[16] = mk(1, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00);
    vecs[17] = mk(1, 0, 8'h00, 0, 1, 8'h42, 1, 8'h40);
    vecs[18] = mk(1, 0, 8'h00, 0, 1, 8'h43, 1, 8'h41);
    vecs[19] = mk(1, 1, 8'hFE, 0, 0, 8'h44, 1, 8'h42);
    vecs[20] = mk(1, 0, 8'h00, 0, 1, 8'hFE, 0, 8'h00);
    vecs[21] = mk(1, 0, 8'h00, 0, 1, 8'hFF, 0, 8'h00);
    vecs[22] = mk(1, 0, 8'h00, 0, 1, 8'h00, 1, 8'hFE);
    vecs[23] = mk(1, 0, 8'h00, 0, 1, 8'h01, 1, 8'hFF);
    vecs[24] = mk(1, 0, 8'h00, 0, 1, 8'h02, 1, 8'h00);
    vecs[25] = mk(1, 0, 8'h00, 1, 0, 8'h03, 1, 8'h01);
    vecs[26] = mk(1, 0, 8'h00, 1, 0, 8'h03, 1, 8'h02);
    vecs[27] = mk(1, 1, 8'h10, 1, 0, 8'h03, 0, 8'h00);
    vecs[28] = mk(1, 0, 8'h00, 1, 0, 8'h10, 0, 8'h00);
    vecs[29] = mk(1, 0, 8'h00, 0, 1, 8'h10, 0, 8'h00);
    vecs[30] = mk(1, 0, 8'h00, 0, 1, 8'h11, 0, 8'h00);
    vecs[31] = mk(1, 1, 8'h20, 0, 0, 8'h12, 1, 8'h10);
    vecs[32] = mk(1, 1, 8'h30, 0, 0, 8'h20, 0, 8'h00);
    vecs[33] = mk(1, 0, 8'h00, 0, 1, 8'h30, 0, 8'h00);
    vecs[34] = mk(1, 0, 8'h00, 0, 1, 8'h31, 0, 8'h00);
    vecs[35] = mk(1, 0, 8'h00, 0, 1, 8'h32, 1, 8'h30);
    vecs[36] = mk(0, 0, 8'h00, 0, 0, 8'h33, 1, 8'h31);
    vecs[37] = mk(0, 0, 8'h00, 0, 0, 8'h33, 1, 8'h31);

    // Program order seen by decode: flushed PCs never appear
    exp_pcs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h40, 8'h41,
                8'h42, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h10, 8'h30};
    foreach (exp_pcs[k]) sb.push_back(exp_pcs[k]);

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst req",    32'(bus.imemReqOut),   32'h0);
    chk("rst valid",  32'(bus.instValidOut), 32'h0);
    chk("rst inst",   bus.instOut,           32'h0);
    chk("rst opcode", 32'(bus.opcodeOut),    32'h0);
    chk("rst pc",     32'(bus.pcOut),        32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle table; cycle 0 is the first cycle after reset release
    for (int i = 0; i < 38; i++) begin
      bus.instReadyIn  = vecs[i].rdy;
      bus.redirectIn   = vecs[i].redir;
      bus.redirectPcIn = vecs[i].rpc;
      bus.haltIn       = vecs[i].halt;
      #1;
      chk($sformatf("c%0d req", i), 32'(bus.imemReqOut), 32'(vecs[i].req));
      if (vecs[i].req)
        chk($sformatf("c%0d addr", i), 32'(bus.imemAddrOut), 32'(vecs[i].addr));
      chk($sformatf("c%0d valid", i), 32'(bus.instValidOut), 32'(vecs[i].vld));
      if (vecs[i].vld)
        chk($sformatf("c%0d head_pc", i), 32'(bus.pcOut), 32'(vecs[i].pc));
      if (bus.instValidOut && bus.instReadyIn) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL c%0d sb_underflow: got handshake pc %0h expected none", i, bus.pcOut);
        end else begin
          e = sb.pop_front();
          chk($sformatf("c%0d sb_pc", i),     32'(bus.pcOut),     32'(e));
          chk($sformatf("c%0d sb_inst", i),   bus.instOut,        inst_of(e));
          chk($sformatf("c%0d sb_opcode", i), 32'(bus.opcodeOut), 32'(inst_of(e) >> 27));
        end
      end
      @(negedge clk);
    end
    chk("sb_leftover", 32'(sb.size()), 32'h0);

    // Reset asserted while an instruction is buffered and a response is arriving
    start_from_reset();
    #1;
    chk("mr c0 req", 32'(bus.imemReqOut), 32'h1);
    @(negedge clk); #1;
    chk("mr c1 addr", 32'(bus.imemAddrOut), 32'h1);
    @(negedge clk); #1;
    chk("mr c2 valid", 32'(bus.instValidOut), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr rst valid",  32'(bus.instValidOut), 32'h0);
    chk("mr rst inst",   bus.instOut,           32'h0);
    chk("mr rst opcode", 32'(bus.opcodeOut),    32'h0);
    chk("mr rst pc",     32'(bus.pcOut),        32'h0);
    chk("mr rst req",    32'(bus.imemReqOut),   32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mr2 c0 req",  32'(bus.imemReqOut),  32'h1);
    chk("mr2 c0 addr", 32'(bus.imemAddrOut), 32'h0);
    @(negedge clk); #1;
    chk("mr2 c1 valid", 32'(bus.instValidOut), 32'h0);
    @(negedge clk); #1;
    chk("mr2 c2 valid", 32'(bus.instValidOut), 32'h1);
    chk("mr2 c2 pc",    32'(bus.pcOut),        32'h0);
    chk("mr2 c2 inst",  bus.instOut,           inst_of(8'h00));
    @(negedge clk);

`ifdef FETCH_PERF_EN
    // 10 stall cycles, then 3 consecutive redirects while ready is high
    start_from_reset();
    #1;
    chk("perf rst stall", 32'(perf_stall), 32'h0);
    chk("perf rst flush", 32'(perf_flush), 32'h0);
    repeat (12) @(negedge clk);
    bus.instReadyIn = 1'b1;
    bus.redirectIn  = 1'b1;
    bus.redirectPcIn = 8'h80;
    repeat (3) @(negedge clk);
    bus.redirectIn = 1'b0;
    #1;
    chk("perf stall10", 32'(perf_stall), 32'd10);
    chk("perf flush3",  32'(perf_flush), 32'd3);
    bus.instReadyIn = 1'b0;
    repeat (65545) @(negedge clk);
    #1;
    chk("perf stall sat", 32'(perf_stall), 32'hFFFF);
    chk("perf flush hold", 32'(perf_flush), 32'd3);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
